// File: rtl/branch_config_scheduler_pkg.sv
// Shared Octavo definitions used by the branch configuration scheduler.
//   OCTAVO_THREAD_COUNT       : default number of hardware threads
//   OCTAVO_THREAD_COUNT_WIDTH : default width of a thread number
//   sched_state_e             : scheduler FSM state encoding
package branch_config_scheduler_pkg;

  localparam int OCTAVO_THREAD_COUNT       = 8;
  localparam int OCTAVO_THREAD_COUNT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no queued request
    ST_WAIT  = 2'd1,  // head queued, waiting for its thread slot
    ST_WRITE = 2'd2   // wren cycle for the head entry
  } sched_state_e;

endpackage

// File: rtl/branch_config_scheduler_fifo.sv
// Branch_Config_FIFO: small synchronous FIFO holding {thread, config} requests.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : oldest entry
//   second_o      : entry behind the head (valid only when count_o > 1)
//   count_o       : number of stored entries
module Branch_Config_FIFO
  import branch_config_scheduler_pkg::*;
#(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         second_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != DEPTH_C);

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign second_o = mem_q[rd_ptr_q + AW'(1)];
  assign count_o  = count_q;

endmodule

// File: rtl/branch_config_scheduler.sv
// branch_config_scheduler: queues branch configuration writes and releases
// each one in the cycle the free-running slot counter (a mirror of the branch
// detector's write thread) equals the request's target thread.
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake (ready while the queue has room)
//   req_thread           : target thread of the request
//   req_config           : configuration word to write
//   wren, configuration  : registered write strobe and data (data 0 when idle)
//   pending              : number of queued requests
//   error                : one-cycle pulse after a request with an illegal thread
module branch_config_scheduler
  import branch_config_scheduler_pkg::*;
#(
  parameter int WORD_WIDTH         = 36,
  parameter int THREAD_COUNT       = OCTAVO_THREAD_COUNT,
  parameter int THREAD_COUNT_WIDTH = OCTAVO_THREAD_COUNT_WIDTH,
  parameter int INITIAL_THREAD     = 0,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [THREAD_COUNT_WIDTH-1:0] req_thread,
  input  logic [WORD_WIDTH-1:0]         req_config,
  output logic                          wren,
  output logic [WORD_WIDTH-1:0]         configuration,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          error
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = THREAD_COUNT_WIDTH + WORD_WIDTH;
  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_SLOT    = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] INIT_SLOT    = THREAD_COUNT_WIDTH'(INITIAL_THREAD);
  localparam logic [THREAD_COUNT_WIDTH:0]   THREAD_LIMIT = (THREAD_COUNT_WIDTH+1)'(THREAD_COUNT);
  localparam logic [PW-1:0]                 DEPTH_C      = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0]                 ONE_C        = PW'(1);

  sched_state_e                  state_q, state_d;
  logic [THREAD_COUNT_WIDTH-1:0] slot_q, slot_d;
  logic                          wren_q, wren_d;
  logic [WORD_WIDTH-1:0]         config_q, config_d;
  logic                          error_q, error_d;

  logic [PW-1:0]                 fifo_count;
  logic [EW-1:0]                 head;
  logic [EW-1:0]                 second;
  logic                          handshake;
  logic                          thread_ok;
  logic                          push;
  logic                          pop;

  // Entries are packed {thread, config}.
  logic [THREAD_COUNT_WIDTH-1:0] head_thread, second_thread;
  logic [WORD_WIDTH-1:0]         head_config, second_config;

  assign head_thread   = head[EW-1:WORD_WIDTH];
  assign head_config   = head[WORD_WIDTH-1:0];
  assign second_thread = second[EW-1:WORD_WIDTH];
  assign second_config = second[WORD_WIDTH-1:0];

  assign req_ready = (fifo_count < DEPTH_C);
  assign handshake = req_valid & req_ready;
  assign thread_ok = ({1'b0, req_thread} < THREAD_LIMIT);
  assign push      = handshake & thread_ok;
  assign pop       = (state_q == ST_WRITE);
  assign error_d   = handshake & ~thread_ok;

  Branch_Config_FIFO #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i ({req_thread, req_config}),
    .pop_i       (pop),
    .head_o      (head),
    .second_o    (second),
    .count_o     (fifo_count)
  );

  // Next slot value, wrapping at THREAD_COUNT-1.
  always_comb begin
    if (slot_q == LAST_SLOT) begin
      slot_d = '0;
    end else begin
      slot_d = slot_q + THREAD_COUNT_WIDTH'(1);
    end
  end

  // FSM next state. WRITE is entered when the *next* slot matches, so the
  // registered wren lines up with the cycle the slot counter equals the thread.
  // From WRITE the entry behind the head is checked directly, which gives
  // back-to-back writes for consecutive threads.
  always_comb begin
    state_d  = state_q;
    wren_d   = 1'b0;
    config_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (head_thread == slot_d) begin
          state_d  = ST_WRITE;
          wren_d   = 1'b1;
          config_d = head_config;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if ((fifo_count > ONE_C) && (second_thread == slot_d)) begin
          state_d  = ST_WRITE;
          wren_d   = 1'b1;
          config_d = second_config;
        end else if ((fifo_count > ONE_C) || push) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, slot counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      slot_q   <= INIT_SLOT;
      wren_q   <= 1'b0;
      config_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      wren_q   <= wren_d;
      config_q <= config_d;
      error_q  <= error_d;
    end
  end

  assign wren          = wren_q;
  assign configuration = config_q;
  assign pending       = fifo_count;
  assign error         = error_q;

endmodule

// File: tb/tb_branch_config_scheduler.sv
// Scoreboard bench: stimulus pushes the hand-computed (cycle, config) of each
// expected write; a monitor on the falling edge pops and compares on wren.
module tb_branch_config_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance (8 threads).
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_thread;
  logic [35:0] req_config;
  logic        wren;
  logic [35:0] configuration;
  logic [2:0]  pending;
  logic        error;

  // Six-thread instance for illegal-thread rejection.
  logic        req_valid_6;
  logic        req_ready_6;
  logic [2:0]  req_thread_6;
  logic [35:0] req_config_6;
  logic        wren_6;
  logic [35:0] configuration_6;
  logic [2:0]  pending_6;
  logic        error_6;

  branch_config_scheduler dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_thread(req_thread), .req_config(req_config),
    .wren(wren), .configuration(configuration),
    .pending(pending), .error(error)
  );

  branch_config_scheduler #(.THREAD_COUNT(6)) dut6 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid_6), .req_ready(req_ready_6),
    .req_thread(req_thread_6), .req_config(req_config_6),
    .wren(wren_6), .configuration(configuration_6),
    .pending(pending_6), .error(error_6)
  );

  // Cycle index since reset release; equals the expected slot modulo 8.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic [35:0] cfg;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (wren) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wren: got config %0h at cycle %0d, none expected", configuration, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("wren_cycle", cyc, mon_e.cyc);
          check("wren_config", configuration, mon_e.cfg);
        end
      end else begin
        check("config_zero_when_idle", configuration, 0);
      end
      check("dut6_no_wren", wren_6, 0);
    end
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present a request during cycle c; ec < 0 means no write is expected.
  task automatic push(input int c, input logic [2:0] th, input logic [35:0] cfg, input int ec);
    goto(c);
    check("ready_at_push", req_ready, 1);
    if (ec >= 0) exp_q.push_back('{ec, cfg});
    req_valid  = 1'b1;
    req_thread = th;
    req_config = cfg;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic reject6(input int c, input logic [2:0] th);
    goto(c);
    check("dut6_ready", req_ready_6, 1);
    req_valid_6  = 1'b1;
    req_thread_6 = th;
    req_config_6 = 36'hEEE;
    @(negedge clk);
    req_valid_6 = 1'b0;
    check("dut6_error_pulse", error_6, 1);
    check("dut6_pending_after_reject", pending_6, 0);
    @(negedge clk);
    check("dut6_error_one_cycle", error_6, 0);
  endtask

  int acc;

  initial begin
    req_valid = 1'b0; req_thread = '0; req_config = '0;
    req_valid_6 = 1'b0; req_thread_6 = '0; req_config_6 = '0;
    repeat (3) @(negedge clk);
    check("reset_pending", pending, 0);
    check("reset_wren", wren, 0);
    check("reset_config", configuration, 0);
    check("reset_error", error, 0);
    rst = 1'b0;
    check("ready_after_reset", req_ready, 1);

    // Single request, thread 5 pushed in cycle 1 -> write in cycle 5.
    push(1, 3'd5, 36'h123, 5);
    check("single_pending", pending, 1);
    check("single_no_error", error, 0);
    goto(6);
    check("single_drained", pending, 0);

    // Threads 3,4,5 queued before slot 3 -> writes in cycles 11,12,13.
    push(8,  3'd3, 36'hA03, 11);
    push(9,  3'd4, 36'hA04, 12);
    push(10, 3'd5, 36'hA05, 13);
    goto(14);
    check("b2b_drained", pending, 0);

    // Same thread twice -> second write eight cycles after the first.
    push(16, 3'd2, 36'h1_2345_6789, 18);
    push(17, 3'd2, 36'hF_EDCB_A987, 26);
    goto(27);
    check("same_thread_drained", pending, 0);

    // Fill the queue; a fifth request waits for the first dequeue.
    push(30, 3'd7, 36'h700, 39);
    push(31, 3'd0, 36'h500, 40);
    push(32, 3'd1, 36'h501, 41);
    push(33, 3'd2, 36'h502, 42);
    check("full_ready_low", req_ready, 0);
    check("full_pending", pending, 4);
    exp_q.push_back('{43, 36'h503});
    req_valid = 1'b1; req_thread = 3'd3; req_config = 36'h503;
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      if (req_ready) acc = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("fifth_accept_cycle", acc, 40);
    check("push_pop_same_cycle_pending", pending, 3);
    goto(44);
    check("full_drained", pending, 0);

    // Six-thread instance: threads 7 and 6 are rejected.
    reject6(46, 3'd7);
    reject6(48, 3'd6);

    // Reset while two entries wait; they must never be written.
    push(52, 3'd1, 36'hBAD, -1);
    push(53, 3'd1, 36'hBAD2, -1);
    check("pre_reset_pending", pending, 2);
    goto(55);
    rst = 1'b1;
    #1;
    check("midreset_pending", pending, 0);
    check("midreset_wren", wren, 0);
    check("midreset_config", configuration, 0);
    check("midreset_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Slot restarts at 0: thread 3 pushed in cycle 1 is written in cycle 3.
    push(1, 3'd3, 36'h333, 3);
    goto(12);
    check("post_reset_drained", pending, 0);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
